load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter QDEPTH, default 4, queue entries (power of two).
REQ-002 SHALL have port clock  in  1  sole clock, rising edge.
REQ-003 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port issue_valid  in  1  issue offers an op this cycle.
REQ-005 SHALL have port issue_ready  out  1  unit accepts the op (queue not full).
REQ-006 SHALL have port issue_op  in  1  0 = load, 1 = store.
REQ-007 SHALL have port issue_tag  in  3  reservation-station tag of the op.
REQ-008 SHALL have port issue_base  in  16  base register value.
REQ-009 SHALL have port issue_offset  in  4  immediate offset.
REQ-010 SHALL have port issue_data  in  16  store data (ignored for loads).
REQ-011 SHALL have port mem_addr  out  4  data-memory address.
REQ-012 SHALL have port mem_write  out  1  data-memory write strobe.
REQ-013 SHALL have port mem_datain  out  16  data to be written to memory.
REQ-014 SHALL have port mem_dataout  in  16  combinational read data from memory.
REQ-015 SHALL have port cdb_valid  out  1  load result offered on the CDB.
REQ-016 SHALL have port cdb_tag  out  3  tag of the offered result.
REQ-017 SHALL have port cdb_data  out  16  loaded value.
REQ-018 SHALL have port cdb_grant  in  1  CDB arbiter accepts the offered result.

Function
REQ-019 SHALL push {op, tag, addr, data} into an in-order FIFO when issue_valid && issue_ready; addr = (issue_base[3:0] + issue_offset) mod 16, computed at push.
REQ-020 SHALL drive issue_ready = 1 iff count < QDEPTH; a pop in the same cycle SHALL NOT free a slot for that cycle's push.
REQ-021 SHALL implement FSM IDLE -> ACCESS -> (BROADCAST | IDLE).
REQ-022 IDLE: if FIFO non-empty, SHALL load mem_addr/mem_datain from the head entry, set mem_write = head.op, and enter ACCESS on the next edge.
REQ-023 ACCESS SHALL last exactly one cycle; mem_addr, mem_datain and mem_write SHALL be registered and stable throughout it.
REQ-024 ACCESS, store: SHALL pop the head at the end of the cycle, clear mem_write, and return to IDLE.
REQ-025 ACCESS, load: SHALL capture mem_dataout into the result register at the end of the cycle, with mem_write = 0, and enter BROADCAST.
REQ-026 BROADCAST: SHALL hold cdb_valid = 1 with stable cdb_tag/cdb_data until cdb_grant is sampled high, then pop the head and return to IDLE.
REQ-027 Memory ops SHALL complete strictly in issue order; a load SHALL observe every earlier store to the same address.
REQ-028 mem_write SHALL be 1 only in the ACCESS cycle of a store, never in any other state.
REQ-029 Store-to-store throughput SHALL be one op per 2 cycles; a load SHALL take at least 3 cycles from FIFO head to CDB release.
REQ-030 Outside ACCESS, mem_addr and mem_datain SHALL hold their last value; mem_write SHALL be 0.
REQ-031 Outside BROADCAST, cdb_valid SHALL be 0; cdb_tag and cdb_data SHALL be don't-care, driven 0.

Reset
REQ-032 resetn low SHALL asynchronously flush the FIFO (count = 0), set state IDLE, and clear mem_write, mem_addr, mem_datain, cdb_valid, cdb_tag and cdb_data to 0.
REQ-033 Reset during ACCESS or BROADCAST SHALL abandon the op without a write or a CDB grant handshake; issue_ready SHALL be 1 after reset.

Structure
REQ-034 Shared package SHALL hold OP_LOAD/OP_STORE encodings, TAG_W = 3, DATA_W = 16, ADDR_W = 4, and the FSM state encoding.
REQ-035 The queue SHALL be a sub-module lsu_fifo (push/pop/full/empty/head, QDEPTH parameter); the FSM and address adder SHALL be in load_store_unit.

Verification
(Memory model preloaded: mem[0..4] = 7, 3, 1, 5, 7.)
REQ-036 Load tag 2, base 1, offset 2 -> mem_addr = 3 in ACCESS; cdb_valid with tag 2, data 5; grant held high -> cdb_valid drops after 1 cycle.
REQ-037 Load tag 1, base 0x000F, offset 1 (wrap) -> mem_addr = 0; cdb_data = 7.
REQ-038 Store tag 3, addr 4, data 0x00AA, then load tag 4 from addr 4 -> exactly one mem_write pulse at addr 4; load returns 0x00AA with tag 4.
REQ-039 Push 4 ops while cdb_grant = 0 -> issue_ready = 0 after the fourth push; cdb_valid held with stable tag/data; grant -> issue_ready = 1 on the next cycle.
REQ-040 Assert resetn low during BROADCAST of a load, with a store queued behind it -> cdb_valid = 0 immediately; no mem_write pulse; queue empty after reset.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and encodings for the load/store unit: op codes, field widths,
// queue entry layout and FSM state encoding.
package load_store_unit_pkg;

  localparam int TAG_W  = 3;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_BROADCAST = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic              op;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } lsu_entry_t;

endpackage

// File: rtl/lsu_fifo.sv
// In-order operation queue for the load/store unit; the head entry is visible
// combinationally and stays put until it is popped.
module lsu_fifo
  import load_store_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       push,
  input  lsu_entry_t push_entry,
  input  logic       pop,
  output lsu_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [PTR_W:0] FULL_CNT = QDEPTH[PTR_W:0];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  lsu_entry_t       slots [QDEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = slots[rd_ptr];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: queues issued memory ops in order, performs one single-cycle
// memory access at a time and broadcasts load results on the CDB.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              issue_op,
  input  logic [TAG_W-1:0]  issue_tag,
  input  logic [DATA_W-1:0] issue_base,
  input  logic [ADDR_W-1:0] issue_offset,
  input  logic [DATA_W-1:0] issue_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_grant
);

  lsu_state_t        state;
  lsu_state_t        next_state;
  lsu_entry_t        push_entry;
  lsu_entry_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              launch;
  logic              capture;
  logic [ADDR_W-1:0] issue_addr;

  // Effective address wraps modulo the 16-word data memory.
  assign issue_addr  = issue_base[ADDR_W-1:0] + issue_offset;
  assign issue_ready = !fifo_full;
  assign push        = issue_valid && issue_ready;
  assign push_entry  = '{op: issue_op, tag: issue_tag, addr: issue_addr, data: issue_data};

  lsu_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    launch     = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          launch     = 1'b1;
          next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (head.op == OP_STORE) begin
          pop        = 1'b1;
          next_state = ST_IDLE;
        end else begin
          capture    = 1'b1;
          next_state = ST_BROADCAST;
        end
      end
      ST_BROADCAST: begin
        if (cdb_grant) begin
          pop        = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Memory-side registers are loaded on entry to ACCESS; the strobe lives one cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_addr   <= '0;
      mem_datain <= '0;
      mem_write  <= 1'b0;
      cdb_valid  <= 1'b0;
      cdb_tag    <= '0;
      cdb_data   <= '0;
    end else begin
      if (launch) begin
        mem_addr   <= head.addr;
        mem_datain <= head.data;
        mem_write  <= (head.op == OP_STORE);
      end else begin
        mem_write  <= 1'b0;
      end
      if (capture) begin
        cdb_valid <= 1'b1;
        cdb_tag   <= head.tag;
        cdb_data  <= mem_dataout;
      end else if (state == ST_BROADCAST && cdb_grant) begin
        cdb_valid <= 1'b0;
        cdb_tag   <= '0;
        cdb_data  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand-written corner sequences
// and randomized traffic against an issue-order memory model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        issue_valid;
  logic        issue_ready;
  logic        issue_op;
  logic [2:0]  issue_tag;
  logic [15:0] issue_base;
  logic [3:0]  issue_offset;
  logic [15:0] issue_data;
  logic [3:0]  mem_addr;
  logic        mem_write;
  logic [15:0] mem_datain;
  logic [15:0] mem_dataout;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        cdb_grant;

  logic [15:0] mem [16];
  assign mem_dataout = mem[mem_addr];

  always #5 clock = ~clock;

  load_store_unit #(.QDEPTH(4)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_op     (issue_op),
    .issue_tag    (issue_tag),
    .issue_base   (issue_base),
    .issue_offset (issue_offset),
    .issue_data   (issue_data),
    .mem_addr     (mem_addr),
    .mem_write    (mem_write),
    .mem_datain   (mem_datain),
    .mem_dataout  (mem_dataout),
    .cdb_valid    (cdb_valid),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .cdb_grant    (cdb_grant)
  );

  typedef struct { logic [3:0] addr; logic [15:0] data; } wr_exp_t;
  typedef struct { logic [2:0] tag;  logic [15:0] data; } ld_exp_t;
  typedef struct {
    logic        op;
    logic [2:0]  tag;
    logic [15:0] base;
    logic [3:0]  off;
    logic [15:0] data;
    logic [3:0]  exp_addr;
    logic [15:0] exp_rd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int occ = 0;
  int writes_seen = 0;
  wr_exp_t wr_q[$];
  ld_exp_t ld_q[$];
  logic [15:0] ref_mem [16];
  logic [15:0] saved_mem [16];

  logic        s_ready, s_write, s_cdb_valid, s_grant;
  logic [3:0]  s_addr;
  logic [15:0] s_datain, s_cdb_data;
  logic [2:0]  s_cdb_tag;
  logic        p_hold = 1'b0;
  logic [2:0]  p_tag;
  logic [15:0] p_data;
  bit          last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Issue-order model: a load sees the memory as left by every store accepted before it.
  task automatic model_accept(input logic op, input logic [2:0] tag, input logic [15:0] base,
                              input logic [3:0] off, input logic [15:0] d);
    int a;
    wr_exp_t w;
    ld_exp_t l;
    a = (int'(base) + int'(off)) % 16;
    if (op) begin
      ref_mem[a] = d;
      w.addr = 4'(a);
      w.data = d;
      wr_q.push_back(w);
    end else begin
      l.tag  = tag;
      l.data = ref_mem[a];
      ld_q.push_back(l);
    end
    occ++;
  endtask

  task automatic tick();
    wr_exp_t w;
    ld_exp_t l;
    @(negedge clock);
    s_ready     = issue_ready;
    s_write     = mem_write;
    s_cdb_valid = cdb_valid;
    s_grant     = cdb_grant;
    s_addr      = mem_addr;
    s_datain    = mem_datain;
    s_cdb_tag   = cdb_tag;
    s_cdb_data  = cdb_data;
    last_acc    = 1'b0;
    if (resetn) begin
      chk("issue_ready_vs_occupancy", 32'(s_ready), (occ < 4) ? 1 : 0);
      if (s_write) begin
        writes_seen++;
        chk("write_expected", (wr_q.size() > 0) ? 1 : 0, 1);
        chk("write_outside_broadcast", 32'(s_cdb_valid), 0);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("write_addr", 32'(s_addr), 32'(w.addr));
          chk("write_data", 32'(s_datain), 32'(w.data));
          occ--;
        end
      end
      if (s_cdb_valid && s_grant) begin
        chk("cdb_expected", (ld_q.size() > 0) ? 1 : 0, 1);
        if (ld_q.size() > 0) begin
          l = ld_q.pop_front();
          chk("cdb_tag", 32'(s_cdb_tag), 32'(l.tag));
          chk("cdb_data", 32'(s_cdb_data), 32'(l.data));
          occ--;
        end
      end
      if (p_hold) begin
        chk("cdb_valid_held", 32'(s_cdb_valid), 1);
        chk("cdb_tag_stable", 32'(s_cdb_tag), 32'(p_tag));
        chk("cdb_data_stable", 32'(s_cdb_data), 32'(p_data));
      end
      if (!s_cdb_valid) chk("cdb_idle_zero", 32'({s_cdb_tag, s_cdb_data}), 0);
      p_hold = s_cdb_valid && !s_grant;
      p_tag  = s_cdb_tag;
      p_data = s_cdb_data;
      if (issue_valid && s_ready) begin
        last_acc = 1'b1;
        model_accept(issue_op, issue_tag, issue_base, issue_offset, issue_data);
      end
    end else begin
      p_hold = 1'b0;
    end
    @(posedge clock);
    cycle++;
    if (resetn && s_write) mem[s_addr] = s_datain;
    #1;
  endtask

  task automatic issue(input logic op, input logic [2:0] tag, input logic [15:0] base,
                       input logic [3:0] off, input logic [15:0] d);
    int budget;
    budget       = 0;
    issue_valid  = 1'b1;
    issue_op     = op;
    issue_tag    = tag;
    issue_base   = base;
    issue_offset = off;
    issue_data   = d;
    do begin
      tick();
      budget++;
    end while (!last_acc && budget < 40);
    chk("issue_accepted", 32'(last_acc), 1);
    issue_valid = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget    = 0;
    cdb_grant = 1'b1;
    while ((occ != 0 || wr_q.size() != 0 || ld_q.size() != 0) && budget < 200) begin
      tick();
      budget++;
    end
    chk("drain_complete", occ, 0);
    repeat (2) tick();
  endtask

  vec_t vecs [7];
  logic [15:0] pre [5];
  int first_evt, vcnt, wcnt, k, wb;
  logic [3:0]  seen_addr;
  logic [2:0]  seen_tag;
  logic [15:0] seen_data;
  int wr_cycles[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pre = '{16'd7, 16'd3, 16'd1, 16'd5, 16'd7};
    for (int i = 0; i < 16; i++) begin
      mem[i]     = (i < 5) ? pre[i] : 16'(16'h0100 + i);
      ref_mem[i] = mem[i];
    end
    vecs[0] = '{op: 1'b0, tag: 3'd2, base: 16'h0001, off: 4'd2,  data: 16'h0000, exp_addr: 4'd3,  exp_rd: 16'h0005};
    vecs[1] = '{op: 1'b0, tag: 3'd1, base: 16'h000F, off: 4'd1,  data: 16'h0000, exp_addr: 4'd0,  exp_rd: 16'h0007};
    vecs[2] = '{op: 1'b1, tag: 3'd3, base: 16'h0002, off: 4'd2,  data: 16'h00AA, exp_addr: 4'd4,  exp_rd: 16'h0000};
    vecs[3] = '{op: 1'b0, tag: 3'd4, base: 16'h0004, off: 4'd0,  data: 16'h0000, exp_addr: 4'd4,  exp_rd: 16'h00AA};
    vecs[4] = '{op: 1'b0, tag: 3'd5, base: 16'hFFF2, off: 4'd0,  data: 16'h0000, exp_addr: 4'd2,  exp_rd: 16'h0001};
    vecs[5] = '{op: 1'b1, tag: 3'd6, base: 16'h000E, off: 4'hF,  data: 16'h1234, exp_addr: 4'hD,  exp_rd: 16'h0000};
    vecs[6] = '{op: 1'b0, tag: 3'd7, base: 16'h0100, off: 4'hD,  data: 16'h0000, exp_addr: 4'hD,  exp_rd: 16'h1234};

    resetn = 1'b0; issue_valid = 1'b0; issue_op = 1'b0; issue_tag = '0;
    issue_base = '0; issue_offset = '0; issue_data = '0; cdb_grant = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_issue_ready", 32'(issue_ready), 1);
    chk("reset_mem_write", 32'(mem_write), 0);
    chk("reset_mem_addr", 32'(mem_addr), 0);
    chk("reset_mem_datain", 32'(mem_datain), 0);
    chk("reset_cdb_valid", 32'(cdb_valid), 0);
    chk("reset_cdb_tag", 32'(cdb_tag), 0);
    chk("reset_cdb_data", 32'(cdb_data), 0);
    resetn = 1'b1;
    repeat (2) tick();

    // Single ops from the vector table, each run to completion with grant held high.
    for (int i = 0; i < 7; i++) begin
      cdb_grant = 1'b1;
      issue(vecs[i].op, vecs[i].tag, vecs[i].base, vecs[i].off, vecs[i].data);
      first_evt = -1; vcnt = 0; wcnt = 0;
      seen_addr = '0; seen_tag = '0; seen_data = '0;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if ((s_write || s_cdb_valid) && first_evt < 0) begin
          first_evt = c;
          seen_addr = s_addr;
        end
        if (s_write) wcnt++;
        if (s_cdb_valid) begin
          vcnt++;
          seen_tag  = s_cdb_tag;
          seen_data = s_cdb_data;
        end
      end
      chk($sformatf("vec%0d_addr", i), 32'(seen_addr), 32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_latency", i), first_evt, vecs[i].op ? 2 : 3);
      chk($sformatf("vec%0d_writes", i), wcnt, vecs[i].op ? 1 : 0);
      chk($sformatf("vec%0d_cdb_cycles", i), vcnt, vecs[i].op ? 0 : 1);
      if (!vecs[i].op) begin
        chk($sformatf("vec%0d_tag", i), 32'(seen_tag), 32'(vecs[i].tag));
        chk($sformatf("vec%0d_data", i), 32'(seen_data), 32'(vecs[i].exp_rd));
      end
    end

    // Fill the queue while the head load waits for a grant.
    cdb_grant = 1'b0;
    issue(1'b0, 3'd1, 16'h0003, 4'd0, 16'h0000);
    issue(1'b1, 3'd2, 16'h0003, 4'd0, 16'h0BEE);
    issue(1'b0, 3'd3, 16'h0003, 4'd0, 16'h0000);
    issue(1'b1, 3'd4, 16'h0007, 4'd1, 16'hCAFE);
    tick();
    chk("full_ready_low", 32'(s_ready), 0);
    chk("full_cdb_valid", 32'(s_cdb_valid), 1);
    chk("full_cdb_tag", 32'(s_cdb_tag), 1);
    repeat (4) tick();
    chk("full_still_blocked", 32'(s_ready), 0);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    tick();
    chk("ready_after_grant", 32'(s_ready), 1);
    drain();
    chk("store_reached_mem", 32'(mem[8]), 32'(16'hCAFE));

    // Back-to-back stores retire one every two cycles.
    wr_cycles.delete();
    issue(1'b1, 3'd0, 16'h0009, 4'd0, 16'h0009);
    if (s_write) wr_cycles.push_back(cycle);
    issue(1'b1, 3'd0, 16'h000A, 4'd0, 16'h000A);
    if (s_write) wr_cycles.push_back(cycle);
    issue(1'b1, 3'd0, 16'h000B, 4'd0, 16'h000B);
    if (s_write) wr_cycles.push_back(cycle);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (s_write) wr_cycles.push_back(cycle);
    end
    chk("store_burst_writes", wr_cycles.size(), 3);
    if (wr_cycles.size() == 3) begin
      chk("store_spacing_1", wr_cycles[1] - wr_cycles[0], 2);
      chk("store_spacing_2", wr_cycles[2] - wr_cycles[1], 2);
    end
    drain();

    // Reset during a load broadcast with a store queued behind it.
    saved_mem = ref_mem;
    cdb_grant = 1'b0;
    issue(1'b0, 3'd5, 16'h0000, 4'd1, 16'h0000);
    issue(1'b1, 3'd6, 16'h0000, 4'd1, 16'hDEAD);
    k = 0;
    while (!s_cdb_valid && k < 10) begin
      tick();
      k++;
    end
    chk("rst_reached_broadcast", 32'(s_cdb_valid), 1);
    resetn = 1'b0;
    #1;
    chk("rst_cdb_valid_async", 32'(cdb_valid), 0);
    chk("rst_cdb_tag_async", 32'(cdb_tag), 0);
    chk("rst_cdb_data_async", 32'(cdb_data), 0);
    chk("rst_mem_write_async", 32'(mem_write), 0);
    chk("rst_mem_addr_async", 32'(mem_addr), 0);
    chk("rst_issue_ready", 32'(issue_ready), 1);
    wr_q.delete();
    ld_q.delete();
    occ = 0;
    ref_mem = saved_mem;
    wb = writes_seen;
    repeat (2) tick();
    resetn = 1'b1;
    cdb_grant = 1'b1;
    repeat (6) tick();
    chk("rst_no_write", writes_seen, wb);
    chk("rst_mem_untouched", 32'(mem[1]), 3);
    chk("rst_queue_empty", 32'(s_ready), 1);
    chk("rst_no_cdb", 32'(s_cdb_valid), 0);

    // Random traffic; the per-cycle scoreboard does the checking.
    for (int c = 0; c < 500; c++) begin
      issue_valid  = ($urandom_range(0, 1) == 1);
      issue_op     = ($urandom_range(0, 1) == 1);
      issue_tag    = 3'($urandom_range(0, 7));
      issue_base   = 16'($urandom);
      issue_offset = 4'($urandom_range(0, 15));
      issue_data   = 16'($urandom);
      cdb_grant    = ($urandom_range(0, 3) != 0);
      tick();
    end
    issue_valid = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), 32'(mem[i]), 32'(ref_mem[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
